fc_stream_core: RTL and testbench
=================================

# fc_stream_core

Fully connected output stage that sits directly downstream of the second spatial convolution core. It consumes that core's pooled feature stream one sample at a time and multiply-accumulates each sample against every neuron's weight from an external weight ROM. When all features of one image are in, it emits saturated Q16.16 logits and the argmax class index.

## Interface
- DATA_WIDTH, 32, data/weight/logit width (signed fixed point)
- FRAC_WIDTH, 16, fractional bits
- ADDR_WIDTH, 16, weight ROM address width
- N_INPUTS, 1600, features per image (5x5x64, kernel-interleaved order as produced upstream)
- N_NEURONS, 10, output neurons
- FC_BASE_ADDR, 0, first weight ROM word
- Clock and reset (already decided): one clock, `clock_i`; reset `reset_ni`, asynchronous, active-low.
- clock_i  in  1  system clock
- reset_ni  in  1  async active-low reset
- clear_i  in  1  restart for next image (sync, level)
- data_valid_i  in  1  feature sample valid
- data_i  in  DATA_WIDTH  feature sample
- hold_data_o  out  1  backpressure; transfer occurs only on data_valid_i && !hold_data_o
- bias_i  in  DATA_WIDTH x N_NEURONS  per-neuron bias (static)
- weight_rdaddress_o  out  ADDR_WIDTH  weight ROM address
- weight_i  in  DATA_WIDTH  weight ROM q (read latency 1)
- logits_o  out  DATA_WIDTH x N_NEURONS  saturated accumulators
- logits_valid_o  out  1  logits_o/class_o final
- class_o  out  $clog2(N_NEURONS)  argmax index
- fc_overflow_o  out  1  sticky: a logit saturated

## Operation
- States: S_LOAD, S_WAIT, S_MAC, S_ARGMAX, S_DONE. hold_data_o = (state != S_WAIT).
- Reset: state S_LOAD, accumulators 0, input counter 0, weight_rdaddress_o = FC_BASE_ADDR, logits_valid_o 0, class_o 0, fc_overflow_o 0; hence logits_o 0, hold_data_o 1.
- S_LOAD (1 cycle): acc[j] <= bias_i[j] sign-extended; -> S_WAIT.
- S_WAIT: on transfer latch data_i, issue address FC_BASE_ADDR + idx*N_NEURONS (input-major layout), -> S_MAC.
- S_MAC: addresses advance +1 per cycle for N_NEURONS words; acc[j] += (data * weight[j]) >>> FRAC_WIDTH (signed 64-bit product, arithmetic shift). After neuron N_NEURONS-1: idx++; -> S_WAIT, or S_ARGMAX if idx reached N_INPUTS (idx reset to 0).
- Accumulators are 2*DATA_WIDTH; no internal overflow possible for the default sizes. logits_o[j] = acc[j] saturated to [0x8000_0000, 0x7FFF_FFFF].
- S_ARGMAX: best=0, compare saturated logits 1..N_NEURONS-1, one per cycle, strictly-greater replaces (ties: lowest index). Final compare sets class_o, logits_valid_o=1, fc_overflow_o |= any saturated, -> S_DONE.
- S_DONE: holds outputs, hold_data_o=1, ignores data.
- clear_i (any state, priority over transfer): logits_valid_o 0, fc_overflow_o 0, idx 0, -> S_LOAD. Mid-image clear discards partial sums.

## Timing
- Transfer at edge E0; hold_data_o high from cycle after E0. Weights for neuron j arrive for MAC at E(j+2); return to S_WAIT at E(N_NEURONS+1): one sample per N_NEURONS+2 cycles (12 default).
- Continuous data_valid_i yields exactly one transfer per S_WAIT visit.
- Last transfer at E0 -> logits_valid_o rises after E(2*N_NEURONS) (20 cycles default).
- After reset release, first transfer possible at second edge (S_LOAD occupies one).
- Reset mid-operation: immediate return to reset values regardless of state.

## Structure
- Shared package cnn_pkg: state enum, Q-format multiply-shift function, saturate-to-DATA_WIDTH function, FRAC_WIDTH default.
- One sub-module, fc_mac_unit: single signed multiply-shift-accumulate with neuron-indexed accumulator bank, load and clear ports; FSM, addressing, argmax in fc_stream_core.

## Test plan
- Reset: hold reset_ni low mid-MAC -> all outputs at reset values; after release hold_data_o low on second cycle, logits_o = biases.
- Small config N_INPUTS=4, N_NEURONS=3, all weights 0x0001_0000, bias 0x0000_8000, inputs 1.0,2.0,3.0,4.0 -> logits 0x000A_8000 each, class_o 0 (tie), fc_overflow_o 0.
- Same config, weights for neuron 2 = 2.0, others 1.0 -> logit[2]=0x0014_8000, class_o 2, valid 2*N_NEURONS cycles after last transfer.
- Backpressure: data_valid_i held high 100 cycles, default params -> exactly one transfer per 12 cycles, ROM address sequence contiguous from FC_BASE_ADDR.
- Saturation: weights 0x7FFF_FFFF, inputs 0x7FFF_FFFF -> logits 0x7FFF_FFFF, fc_overflow_o 1; negative weights -> 0x8000_0000.
- clear_i mid-image then full image -> results identical to clean run; clear_i in S_DONE drops logits_valid_o and overflow next cycle.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared fixed-point helpers and FSM encoding for the CNN output stages.
// Accumulators are 64-bit signed; data operands up to 32 bits fit without loss.
package cnn_pkg;

    localparam int FRAC_WIDTH_DEF = 16;
    localparam int ACC_WIDTH      = 64;

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    typedef enum logic [2:0] {
        S_LOAD,
        S_WAIT,
        S_MAC,
        S_ARGMAX,
        S_DONE
    } fc_state_t;

    // Qm.f multiply: full-width signed product, arithmetic shift back to the input scale.
    function automatic acc_t q_mul_shift(input acc_t a, input acc_t b, input int frac);
        acc_t prod;
        prod = a * b;
        return prod >>> frac;
    endfunction

    function automatic acc_t saturate(input acc_t v, input int width);
        acc_t hi;
        acc_t lo;
        hi = (acc_t'(1) <<< (width - 1)) - acc_t'(1);
        lo = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Neuron-indexed accumulator bank: bias load, clear, and one signed Q multiply-accumulate per cycle.
// Accumulate lands one edge after mac_en; no backpressure (caller schedules every operation).
module fc_mac_unit
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
    parameter int N_NEURONS  = 10,
    parameter int SEL_WIDTH  = $clog2(N_NEURONS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic                            load,
    input  logic [DATA_WIDTH*N_NEURONS-1:0] bias,
    input  logic                            mac_en,
    input  logic [SEL_WIDTH-1:0]            sel,
    input  logic [DATA_WIDTH-1:0]           data,
    input  logic [DATA_WIDTH-1:0]           weight,
    output logic [ACC_WIDTH*N_NEURONS-1:0]  acc
);

    acc_t acc_q [N_NEURONS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N_NEURONS; j++) acc_q[j] <= '0;
        end else if (clear) begin
            for (int j = 0; j < N_NEURONS; j++) acc_q[j] <= '0;
        end else if (load) begin
            // Biases share the Q format of the logits, so only sign extension is needed.
            for (int j = 0; j < N_NEURONS; j++)
                acc_q[j] <= acc_t'($signed(bias[j*DATA_WIDTH +: DATA_WIDTH]));
        end else if (mac_en) begin
            acc_q[sel] <= acc_q[sel] + q_mul_shift(acc_t'($signed(data)),
                                                   acc_t'($signed(weight)), FRAC_WIDTH);
        end
    end

    for (genvar j = 0; j < N_NEURONS; j++) begin : g_out
        assign acc[j*ACC_WIDTH +: ACC_WIDTH] = acc_q[j];
    end

endmodule

// File: rtl/fc_stream_core.sv
// Fully connected output stage: streams features against ROM weights, then argmax over saturated logits.
// One sample per N_NEURONS+2 cycles; hold_data_o stays high outside S_WAIT.
module fc_stream_core
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FRAC_WIDTH   = FRAC_WIDTH_DEF,
    parameter int ADDR_WIDTH   = 16,
    parameter int N_INPUTS     = 1600,
    parameter int N_NEURONS    = 10,
    parameter int FC_BASE_ADDR = 0
) (
    input  logic                            clock_i,
    input  logic                            reset_ni,
    input  logic                            clear_i,
    input  logic                            data_valid_i,
    input  logic [DATA_WIDTH-1:0]           data_i,
    output logic                            hold_data_o,
    input  logic [DATA_WIDTH*N_NEURONS-1:0] bias_i,
    output logic [ADDR_WIDTH-1:0]           weight_rdaddress_o,
    input  logic [DATA_WIDTH-1:0]           weight_i,
    output logic [DATA_WIDTH*N_NEURONS-1:0] logits_o,
    output logic                            logits_valid_o,
    output logic [$clog2(N_NEURONS)-1:0]    class_o,
    output logic                            fc_overflow_o
);

    localparam int IDX_W = $clog2(N_INPUTS + 1);
    localparam int MC_W  = $clog2(N_NEURONS + 1);
    localparam int CLS_W = $clog2(N_NEURONS);

    fc_state_t                       state;
    fc_state_t                       state_nxt;
    logic [DATA_WIDTH-1:0]           data_q;
    logic [IDX_W-1:0]                idx;
    logic [MC_W-1:0]                 mcnt;
    logic [CLS_W-1:0]                acnt;
    logic [CLS_W-1:0]                best;
    logic [CLS_W-1:0]                winner;
    logic [ACC_WIDTH*N_NEURONS-1:0]  acc_bus;
    logic signed [DATA_WIDTH-1:0]    logit [N_NEURONS];
    logic [N_NEURONS-1:0]            sat_flag;
    logic                            transfer;
    logic                            mac_last;
    logic                            last_input;
    logic                            cmp_last;
    logic                            load;
    logic                            mac_en;
    logic [CLS_W-1:0]                mac_sel;

    assign hold_data_o = (state != S_WAIT);
    assign transfer    = (state == S_WAIT) && data_valid_i && !clear_i;
    assign mac_last    = (mcnt == MC_W'(N_NEURONS));
    assign last_input  = (idx == IDX_W'(N_INPUTS - 1));
    assign cmp_last    = (acnt == CLS_W'(N_NEURONS - 1));
    assign winner      = (logit[acnt] > logit[best]) ? acnt : best;

    // ROM read latency is one cycle, so mcnt=k accumulates the weight addressed at mcnt=k-1.
    assign load    = (state == S_LOAD) && !clear_i;
    assign mac_en  = (state == S_MAC) && (mcnt != '0) && !clear_i;
    assign mac_sel = CLS_W'(mcnt - MC_W'(1));

    for (genvar j = 0; j < N_NEURONS; j++) begin : g_logit
        acc_t acc_j;
        acc_t sat_j;
        assign acc_j       = acc_bus[j*ACC_WIDTH +: ACC_WIDTH];
        assign sat_j       = saturate(acc_j, DATA_WIDTH);
        assign logit[j]    = sat_j[DATA_WIDTH-1:0];
        assign sat_flag[j] = (sat_j != acc_j);
        assign logits_o[j*DATA_WIDTH +: DATA_WIDTH] = logit[j];
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) state <= S_LOAD;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:   state_nxt = S_WAIT;
            S_WAIT:   if (transfer) state_nxt = S_MAC;
            S_MAC:    if (mac_last) state_nxt = last_input ? S_ARGMAX : S_WAIT;
            S_ARGMAX: if (cmp_last) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_DONE;
            default:  state_nxt = S_LOAD;
        endcase
        if (clear_i) state_nxt = S_LOAD;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            data_q             <= '0;
            weight_rdaddress_o <= ADDR_WIDTH'(FC_BASE_ADDR);
            idx                <= '0;
            mcnt               <= '0;
            acnt               <= '0;
            best               <= '0;
            class_o            <= '0;
            logits_valid_o     <= 1'b0;
            fc_overflow_o      <= 1'b0;
        end else if (clear_i) begin
            idx            <= '0;
            mcnt           <= '0;
            logits_valid_o <= 1'b0;
            fc_overflow_o  <= 1'b0;
        end else begin
            case (state)
                S_WAIT: if (data_valid_i) begin
                    data_q             <= data_i;
                    weight_rdaddress_o <= ADDR_WIDTH'(FC_BASE_ADDR)
                                          + ADDR_WIDTH'(idx) * ADDR_WIDTH'(N_NEURONS);
                    mcnt               <= '0;
                end
                S_MAC: begin
                    mcnt <= mcnt + MC_W'(1);
                    if (mcnt < MC_W'(N_NEURONS - 1))
                        weight_rdaddress_o <= weight_rdaddress_o + ADDR_WIDTH'(1);
                    if (mac_last) begin
                        idx  <= last_input ? '0 : idx + IDX_W'(1);
                        mcnt <= '0;
                        acnt <= CLS_W'(1);
                        best <= '0;
                    end
                end
                S_ARGMAX: begin
                    best <= winner;
                    acnt <= acnt + CLS_W'(1);
                    if (cmp_last) begin
                        class_o        <= winner;
                        logits_valid_o <= 1'b1;
                        fc_overflow_o  <= fc_overflow_o | (|sat_flag);
                    end
                end
                default: ;
            endcase
        end
    end

    fc_mac_unit #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_WIDTH(FRAC_WIDTH),
        .N_NEURONS (N_NEURONS),
        .SEL_WIDTH (CLS_W)
    ) u_mac (
        .clk   (clock_i),
        .rst_n (reset_ni),
        .clear (clear_i),
        .load  (load),
        .bias  (bias_i),
        .mac_en(mac_en),
        .sel   (mac_sel),
        .data  (data_q),
        .weight(weight_i),
        .acc   (acc_bus)
    );

endmodule

// File: tb/tb_fc_stream_core.sv
// Bench for fc_stream_core: a 4-input/3-neuron instance driven from a vector table with a
// scoreboard, plus a default-size instance for reset and backpressure sequences.
module tb_fc_stream_core;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // small instance: 4 inputs, 3 neurons
    logic        s_clear, s_valid, s_hold, s_lv, s_ovf;
    logic [31:0] s_data, s_weight;
    logic [95:0] s_bias, s_logits;
    logic [15:0] s_addr;
    logic [1:0]  s_cls;
    logic [31:0] s_rom [12];

    always @(posedge clk) s_weight <= (s_addr < 16'd12) ? s_rom[s_addr[3:0]] : 32'd0;

    fc_stream_core #(.N_INPUTS(4), .N_NEURONS(3)) u_small (
        .clock_i(clk), .reset_ni(rst_n), .clear_i(s_clear), .data_valid_i(s_valid),
        .data_i(s_data), .hold_data_o(s_hold), .bias_i(s_bias),
        .weight_rdaddress_o(s_addr), .weight_i(s_weight), .logits_o(s_logits),
        .logits_valid_o(s_lv), .class_o(s_cls), .fc_overflow_o(s_ovf)
    );

    // default-size instance
    logic         d_clear, d_valid, d_hold, d_lv, d_ovf;
    logic [31:0]  d_data, d_weight;
    logic [319:0] d_bias, d_logits;
    logic [15:0]  d_addr;
    logic [3:0]   d_cls;

    always @(posedge clk) d_weight <= {16'd0, d_addr};

    fc_stream_core u_dflt (
        .clock_i(clk), .reset_ni(rst_n), .clear_i(d_clear), .data_valid_i(d_valid),
        .data_i(d_data), .hold_data_o(d_hold), .bias_i(d_bias),
        .weight_rdaddress_o(d_addr), .weight_i(d_weight), .logits_o(d_logits),
        .logits_valid_o(d_lv), .class_o(d_cls), .fc_overflow_o(d_ovf)
    );

    typedef struct {
        logic [3:0][31:0] x;
        logic [2:0][31:0] w;
        logic [2:0][31:0] bias;
        logic [2:0][31:0] logit;
        logic [1:0]       cls;
        logic             ovf;
    } vec_t;

    typedef struct {
        logic [2:0][31:0] logit;
        logic [1:0]       cls;
        logic             ovf;
    } exp_t;

    vec_t tv [6];
    exp_t sb [$];
    exp_t e_mon;
    int   n_out = 0;
    int   rise_edge = 0;
    logic s_lv_prev = 1'b0;

    always @(negedge clk) begin
        if (s_lv && !s_lv_prev) begin
            n_out++;
            rise_edge = ecount;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got logits_valid 1 want 0 (no image pending)");
            end else begin
                e_mon = sb.pop_front();
                for (int j = 0; j < 3; j++)
                    chk($sformatf("logit%0d", j), s_logits[j*32 +: 32], e_mon.logit[j]);
                chk("class", s_cls, e_mon.cls);
                chk("overflow", s_ovf, e_mon.ovf);
            end
        end
        s_lv_prev = s_lv;
    end

    task automatic load_vec(input int v);
        for (int j = 0; j < 3; j++) s_bias[j*32 +: 32] = tv[v].bias[j];
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++) s_rom[i*3 + j] = tv[v].w[j];
    endtask

    task automatic feed(input logic [31:0] x, output int t);
        int g;
        g = 0;
        s_data  = x;
        s_valid = 1'b1;
        while (s_hold && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (s_hold) begin
            chk("feed_hold", s_hold, 64'd0);
            t = -1;
        end else begin
            @(posedge clk);
            @(negedge clk);
            t = ecount;
        end
    endtask

    task automatic run_vec(input int v);
        exp_t e;
        int   t [4];
        int   n0;
        int   g;
        load_vec(v);
        s_valid = 1'b0;
        s_clear = 1'b1;
        @(negedge clk);
        s_clear = 1'b0;
        e.logit = tv[v].logit;
        e.cls   = tv[v].cls;
        e.ovf   = tv[v].ovf;
        sb.push_back(e);
        n0 = n_out;
        for (int k = 0; k < 4; k++) feed(tv[v].x[k], t[k]);
        s_valid = 1'b0;
        for (int k = 1; k < 4; k++) chk($sformatf("v%0d_spacing%0d", v, k), t[k] - t[k-1], 5);
        g = 0;
        while (n_out == n0 && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (n_out == n0) chk("valid_timeout", n_out, n0 + 1);
        else             chk($sformatf("v%0d_latency", v), rise_edge - t[3], 6);
    endtask

    initial begin
        int n_xfer;
        int last_t;
        int prev_addr;
        int tdummy;

        // inputs x[0..3], weights/bias/logits per neuron [0..2]; concatenations list highest index first
        tv[0].x = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
        tv[0].w = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        tv[0].bias  = {32'h0000_8000, 32'h0000_8000, 32'h0000_8000};
        tv[0].logit = {32'h000A_8000, 32'h000A_8000, 32'h000A_8000};
        tv[0].cls = 2'd0; tv[0].ovf = 1'b0;

        tv[1].x = tv[0].x;
        tv[1].w = {32'h0002_0000, 32'h0001_0000, 32'h0001_0000};
        tv[1].bias  = tv[0].bias;
        tv[1].logit = {32'h0014_8000, 32'h000A_8000, 32'h000A_8000};
        tv[1].cls = 2'd2; tv[1].ovf = 1'b0;

        tv[2].x = {4{32'h7FFF_FFFF}};
        tv[2].w = {3{32'h7FFF_FFFF}};
        tv[2].bias  = '0;
        tv[2].logit = {3{32'h7FFF_FFFF}};
        tv[2].cls = 2'd0; tv[2].ovf = 1'b1;

        tv[3].x = {4{32'h7FFF_FFFF}};
        tv[3].w = {3{32'h8000_0001}};
        tv[3].bias  = '0;
        tv[3].logit = {3{32'h8000_0000}};
        tv[3].cls = 2'd0; tv[3].ovf = 1'b1;

        tv[4].x = {32'h0002_0000, 32'h0000_8000, 32'hFFFF_0000, 32'h0001_0000};
        tv[4].w = {32'hFFFF_0000, 32'h0000_8000, 32'h0001_0000};
        tv[4].bias  = {32'h0000_0000, 32'h0001_0000, 32'hFFFF_0000};
        tv[4].logit = {32'hFFFD_8000, 32'h0002_4000, 32'h0001_8000};
        tv[4].cls = 2'd1; tv[4].ovf = 1'b0;

        tv[5].x = {4{32'h0000_0001}};
        tv[5].w = {32'h0001_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        tv[5].bias  = '0;
        tv[5].logit = {32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFC};
        tv[5].cls = 2'd2; tv[5].ovf = 1'b0;

        rst_n = 1'b0;
        s_clear = 1'b0; s_valid = 1'b0; s_data = '0; s_bias = '0;
        d_clear = 1'b0; d_valid = 1'b0; d_data = '0;
        for (int i = 0; i < 12; i++) s_rom[i] = '0;
        for (int j = 0; j < 10; j++) d_bias[j*32 +: 32] = 32'(j) * 32'h0101_0101 - 32'h0300_0000;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_hold_first_cycle", d_hold, 64'd1);
        @(negedge clk);
        chk("rst_hold_second_cycle", d_hold, 64'd0);

        // one sample into the default core, then reset in the middle of its MAC burst
        d_valid = 1'b1;
        d_data  = 32'h0001_0000;
        @(negedge clk);
        d_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_hold", d_hold, 64'd1);
        chk("arst_addr", d_addr, 64'd0);
        chk("arst_valid", d_lv, 64'd0);
        chk("arst_class", d_cls, 64'd0);
        chk("arst_ovf", d_ovf, 64'd0);
        chk("arst_logits_lo", d_logits[63:0], 64'd0);
        chk("arst_logits_hi", d_logits[319:256], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel_hold_first", d_hold, 64'd1);
        @(negedge clk);
        chk("rel_hold_second", d_hold, 64'd0);
        for (int j = 0; j < 10; j++)
            chk($sformatf("rel_bias%0d", j), d_logits[j*32 +: 32], d_bias[j*32 +: 32]);

        // continuous valid for 100 cycles on the default core
        n_xfer = 0;
        last_t = -1;
        prev_addr = int'(d_addr);
        d_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            d_data = 32'(c) << 12;
            if (d_valid && !d_hold) begin
                n_xfer++;
                if (last_t >= 0) chk("bp_spacing", c - last_t, 12);
                last_t = c;
            end
            if (int'(d_addr) != prev_addr) begin
                chk("bp_addr_step", d_addr, 64'(prev_addr + 1));
                prev_addr = int'(d_addr);
            end
            @(negedge clk);
        end
        d_valid = 1'b0;
        chk("bp_transfers", n_xfer, 64'd9);

        // table of images through the small core
        for (int v = 0; v < 6; v++) run_vec(v);

        // clear mid-image, asserted while a transfer is being offered
        load_vec(4);
        s_clear = 1'b1;
        @(negedge clk);
        s_clear = 1'b0;
        feed(tv[4].x[0], tdummy);
        feed(tv[4].x[1], tdummy);
        s_data  = tv[4].x[2];
        s_valid = 1'b1;
        for (int g = 0; g < 50 && s_hold; g++) @(negedge clk);
        s_clear = 1'b1;
        @(negedge clk);
        s_clear = 1'b0;
        s_valid = 1'b0;
        chk("clear_beats_transfer_addr", s_addr, 64'd5);
        run_vec(4);

        // S_DONE ignores data; clear there drops valid and overflow
        run_vec(2);
        s_valid = 1'b1;
        s_data  = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("done_hold", s_hold, 64'd1);
            chk("done_valid", s_lv, 64'd1);
            chk("done_logit0", s_logits[31:0], 64'h7FFF_FFFF);
        end
        s_valid = 1'b0;
        s_clear = 1'b1;
        @(negedge clk);
        s_clear = 1'b0;
        chk("clr_done_valid", s_lv, 64'd0);
        chk("clr_done_ovf", s_ovf, 64'd0);
        chk("clr_done_hold", s_hold, 64'd1);
        @(negedge clk);
        chk("clr_done_wait", s_hold, 64'd0);
        chk("clr_done_bias", s_logits[31:0], 64'd0);
        chk("sb_drained", sb.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
